// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU definitions: operation encoding, arbiter FSM states and the
// default requester count.
package aluPkg;

    localparam int NREQ_DEFAULT = 2;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU
    } alu_op;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Purely combinational ALU; the output depends only on the three inputs.
module alu #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] alu_in1,
    input  logic [XLEN-1:0] alu_in2,
    input  aluPkg::alu_op   alu_op,
    output logic [XLEN-1:0] alu_out
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;

    assign shamt = alu_in2[SHW-1:0];

    always_comb begin
        alu_out = '0;
        case (alu_op)
            aluPkg::ALU_ADD:  alu_out = alu_in1 + alu_in2;
            aluPkg::ALU_SUB:  alu_out = alu_in1 - alu_in2;
            aluPkg::ALU_AND:  alu_out = alu_in1 & alu_in2;
            aluPkg::ALU_OR:   alu_out = alu_in1 | alu_in2;
            aluPkg::ALU_XOR:  alu_out = alu_in1 ^ alu_in2;
            aluPkg::ALU_SLL:  alu_out = alu_in1 << shamt;
            aluPkg::ALU_SRL:  alu_out = alu_in1 >> shamt;
            aluPkg::ALU_SRA:  alu_out = $signed(alu_in1) >>> shamt;
            aluPkg::ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, $signed(alu_in1) < $signed(alu_in2)};
            aluPkg::ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, alu_in1 < alu_in2};
            default:          alu_out = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational alu among NREQ requesters, with a
// registered response tagged by the owning requester's id.
module alu_share_arbiter
    import aluPkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int XLEN = 32,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  alu_op           req_op  [NREQ],
    input  logic [XLEN-1:0] req_in1 [NREQ],
    input  logic [XLEN-1:0] req_in2 [NREQ],
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [IDW-1:0]  rsp_id,
    output logic            busy
);

    arb_state_t      state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    alu_op           op_q;
    logic [XLEN-1:0] in1_q, in2_q;
    logic [IDW-1:0]  id_q;
    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_data_q;
    logic [IDW-1:0]  rsp_id_q;

    logic            pick_found;
    logic [IDW-1:0]  pick_idx;
    logic            take;
    logic [NREQ-1:0] grant;
    logic [XLEN-1:0] alu_res;

    // Returns {found, index} of the first valid requester at or after ptr, with wrap.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] ptr);
        logic            found;
        logic [IDW-1:0]  sel;
        int unsigned     idx;
        found = 1'b0;
        sel   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!found && v[idx]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
        return {found, sel};
    endfunction

    always_comb begin
        {pick_found, pick_idx} = rr_pick(req_valid, rr_ptr_q);
        take     = 1'b0;
        grant    = '0;
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: take = pick_found;
            EXEC: state_d = HOLD;
            HOLD: begin
                if (rsp_ready) begin
                    take    = pick_found;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            grant[pick_idx] = 1'b1;
            state_d         = EXEC;
            rr_ptr_d        = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    // The reset term keeps the strobe low while the state is forced to IDLE.
    assign req_ready = rst_n ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_q        <= ALU_ADD;
            in1_q       <= '0;
            in2_q       <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            if (take) begin
                op_q  <= req_op[pick_idx];
                in1_q <= req_in1[pick_idx];
                in2_q <= req_in2[pick_idx];
                id_q  <= pick_idx;
            end
            if (state_q == EXEC) begin
                rsp_data_q  <= alu_res;
                rsp_id_q    <= id_q;
                rsp_valid_q <= 1'b1;
            end else if (state_q == HOLD && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    alu #(
        .XLEN(XLEN)
    ) u_alu (
        .alu_in1(in1_q),
        .alu_in2(in2_q),
        .alu_op (op_q),
        .alu_out(alu_res)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational `alu` instance between NREQ requesters, e.g. the execute stage and the address-generation / CSR path of rysyCore.
- Round-robin arbitration, valid/ready handshake per requester, and a registered response with the winning requester's id.
- Sits between the requesters and the single `alu`; only this block drives `alu_in1`, `alu_in2` and `alu_op`.

Parameters:
- NREQ, 2, number of requesters (2..8).
- XLEN, 32, operand and result width; must match the `alu` datapath width.
- IDW, $clog2(NREQ) (minimum 1), width of the requester id.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept strobe; at most one bit set (one-hot or zero).
- req_op  in  NREQ x aluPkg::alu_op  requested operation.
- req_in1  in  NREQ x XLEN  operand 1.
- req_in2  in  NREQ x XLEN  operand 2.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  XLEN  registered ALU result.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE, rr_ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
  - Latched op = first enumerator of aluPkg::alu_op; latched operands = 0.
  - req_ready=0 while rst_n=0.
  - Any in-flight request is dropped and no response is produced for it.
- FSM states:
  - IDLE: grant the first requester with req_valid=1, searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
    - req_ready[g] is driven combinationally in this cycle.
    - On the clock edge: latch req_op[g], req_in1[g], req_in2[g] and g; set rr_ptr=(g+1) mod NREQ; go to EXEC.
    - No valid requester: stay in IDLE, req_ready=0.
  - EXEC: `alu` is fed only from the latched registers, never from the req_* ports.
    - On the edge: rsp_data<=alu_out, rsp_id<=latched id, rsp_valid<=1; go to HOLD.
    - req_ready=0.
  - HOLD: rsp_valid=1; rsp_data and rsp_id are stable.
    - rsp_ready=0: stay in HOLD, req_ready=0.
    - rsp_ready=1 and no req_valid: rsp_valid<=0, go to IDLE.
    - rsp_ready=1 and any req_valid: arbitrate exactly as in IDLE in the same cycle (req_ready[g]=1), latch the new request, rsp_valid<=0, go to EXEC. This is the back-to-back path.
- Latency:
  - Request handshake at edge E0; rsp_valid rises after E0+1.
  - Sustained throughput is one result per 2 cycles.
- Handshake rules:
  - A transfer occurs when req_valid[i] & req_ready[i] are both high at a rising edge.
  - A requester keeps its fields stable while valid and not yet accepted.
  - Deasserting req_valid before acceptance is legal and has no side effects.
  - A response transfer occurs when rsp_valid & rsp_ready are both high at a rising edge.
- Arithmetic and width:
  - Results are whatever `alu` produces. No extra sign or zero extension; overflow wraps modulo 2^XLEN.
- Fairness: a continuously requesting requester waits at most NREQ-1 grants.
- Boundaries:
  - All requesters valid: strict rotation 0,1,...,NREQ-1,0.
  - rr_ptr wraps from NREQ-1 to 0.
  - rsp_ready held low indefinitely: HOLD persists with no loss and no reordering.
  - rsp_ready high outside HOLD: ignored.

Decomposition:
- aluPkg (shared, existing): keeps `alu_op`. Add:
  - typedef `arb_state_t` {IDLE, EXEC, HOLD};
  - a localparam default for NREQ.
- One sub-module: the existing `alu`, instantiated once (`alu_in1`, `alu_in2`, `alu_op`, `alu_out`).
- The round-robin picker stays a function inside this block; it is not a separate module.

Test Plan:
- Single request: after reset, req 0 issues ADD with in1=10, in2=2. Expect req_ready[0]=1 in the first cycle; two edges later rsp_valid=1, rsp_data=12, rsp_id=0.
- Negative operand: req 1 issues ADD with in1=-16 (32'hFFFF_FFF0), in2=2. Expect rsp_data=32'hFFFF_FFF2, rsp_id=1.
- Contention: req 0 and req 1 both hold ADD requests continuously, rsp_ready=1. Expect grants in the order 0,1,0,1, one result every 2 cycles, rsp_id alternating.
- Backpressure: rsp_ready=0 for 5 cycles after SUB with in1=3, in2=10.
  - rsp_data=32'hFFFF_FFF9 is held stable.
  - req_ready stays 0 and busy=1.
  - On release, rsp_valid drops and a pending request is granted in the same cycle.
- Reset mid-operation: assert rst_n=0 asynchronously while in EXEC. Expect immediately rsp_valid=0, busy=0, rsp_data=0; after release, the first grant goes to req 0.
- Op sweep: walk every aluPkg::alu_op through requester 0 with the operand pairs (10,2), (3,10), (-4,4), (4,-4), (-16,2). Compare each result against a standalone `alu` model.
